// File: rtl/imem_loader_if.sv
// Boot-channel byte stream plus instruction-memory write port, bundled.
// The loader takes the "slave" view: it receives bytes and drives the
// write port. The environment (boot source + instr_mem) takes "master".
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length-prefixed byte stream,
// packs it into little-endian words, writes them from BASE_ADDR upward
// and holds the core in reset until the whole image has landed.
module imem_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_reset,
    output logic          busy,
    output logic          done,
    output logic          error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Word count limit, one bit wider than the header so 2**ADDR_W fits.
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    state_t              state_q,      state_d;
    logic [1:0]          byte_idx_q,   byte_idx_d;
    logic [31:0]         shift_q,      shift_d;
    logic [31:0]         word_count_q, word_count_d;
    logic [ADDR_W-1:0]   word_idx_q,   word_idx_d;
    logic                wr_en_q,      wr_en_d;
    logic [31:0]         wr_addr_q,    wr_addr_d;
    logic [31:0]         wr_data_q,    wr_data_d;

    logic        byte_ready;
    logic        byte_fire;
    logic        last_write;
    logic [31:0] next_word;
    logic [31:0] word_idx_ext;

    // Handshake and helpers: the last write cycle already refuses bytes.
    always_comb begin
        word_idx_ext = 32'(word_idx_q);
        next_word    = {bus.byte_data, shift_q[31:8]};
        last_write   = wr_en_q && (word_idx_ext == (word_count_q - 32'd1));
        case (state_q)
            ST_HDR:  byte_ready = 1'b1;
            ST_LOAD: byte_ready = !last_write;
            default: byte_ready = 1'b0;
        endcase
        byte_fire = bus.byte_valid && byte_ready;
    end

    // Next-state logic: header parse, word assembly and write scheduling.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        word_count_d = word_count_q;
        word_idx_d   = word_idx_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d      = ST_HDR;
                    byte_idx_d   = 2'd0;
                    shift_d      = 32'd0;
                    word_count_d = 32'd0;
                    word_idx_d   = '0;
                end
            end

            ST_HDR: begin
                if (byte_fire) begin
                    shift_d    = next_word;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        word_count_d = next_word;
                        word_idx_d   = '0;
                        if (next_word == 32'd0) begin
                            state_d = ST_DONE;
                        end else if ({1'b0, next_word} > CAPACITY) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
            end

            ST_LOAD: begin
                if (wr_en_q) begin
                    word_idx_d = word_idx_q + ADDR_W'(1);
                    if (last_write) begin
                        state_d = ST_DONE;
                    end
                end
                if (byte_fire) begin
                    shift_d    = next_word;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = BASE_ADDR + {word_idx_ext[29:0], 2'b00};
                        wr_data_d = next_word;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial image.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= 2'd0;
            shift_q      <= 32'd0;
            word_count_q <= 32'd0;
            word_idx_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 32'd0;
            wr_data_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            word_count_q <= word_count_d;
            word_idx_q   <= word_idx_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // Status outputs decoded straight from the registered state.
    always_comb begin
        bus.byte_ready = byte_ready;
        bus.wr_en      = wr_en_q;
        bus.wr_addr    = wr_addr_q;
        bus.wr_data    = wr_data_q;
        core_reset     = (state_q != ST_DONE);
        busy           = (state_q == ST_HDR) || (state_q == ST_LOAD);
        done           = (state_q == ST_DONE);
        error          = (state_q == ST_ERROR);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default instance (ADDR_W=10, base 0)
// plus a small instance (ADDR_W=2, base 0x100) for the full-capacity case.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a;
    logic       start_b;
    logic       sel;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready_sel;

    logic core_reset_a, busy_a, done_a, error_a;
    logic core_reset_b, busy_b, done_b, error_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int cycle        = 0;

    logic [31:0] wa_addr[$];
    logic [31:0] wa_data[$];
    logic [31:0] wb_addr[$];
    logic [31:0] wb_data[$];
    int          wb_cyc[$];

    imem_loader_if bus_a ();
    imem_loader_if bus_b ();

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure spacing between writes.
    always @(posedge clk) cycle <= cycle + 1;

    // Route the single byte source to whichever instance is selected.
    assign bus_a.byte_valid = byte_valid && !sel;
    assign bus_b.byte_valid = byte_valid && sel;
    assign bus_a.byte_data  = byte_data;
    assign bus_b.byte_data  = byte_data;
    assign byte_ready_sel   = sel ? bus_b.byte_ready : bus_a.byte_ready;

    imem_loader dut_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start_a),
        .bus        (bus_a),
        .core_reset (core_reset_a),
        .busy       (busy_a),
        .done       (done_a),
        .error      (error_a)
    );

    imem_loader #(.ADDR_W(2), .BASE_ADDR(32'h0000_0100)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start_b),
        .bus        (bus_b),
        .core_reset (core_reset_b),
        .busy       (busy_b),
        .done       (done_b),
        .error      (error_b)
    );

    // Log every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_a.wr_en === 1'b1) begin
            wa_addr.push_back(bus_a.wr_addr);
            wa_data.push_back(bus_a.wr_data);
        end
        if (bus_b.wr_en === 1'b1) begin
            wb_addr.push_back(bus_b.wr_addr);
            wb_data.push_back(bus_b.wr_data);
            wb_cyc.push_back(cycle);
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, required finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check_bit({pfx, " byte_ready"}, bus_a.byte_ready, 1'b0);
        check_bit({pfx, " wr_en"}, bus_a.wr_en, 1'b0);
        check_output({pfx, " wr_addr"}, bus_a.wr_addr, 32'h0);
        check_output({pfx, " wr_data"}, bus_a.wr_data, 32'h0);
        check_bit({pfx, " core_reset"}, core_reset_a, 1'b1);
        check_bit({pfx, " busy"}, busy_a, 1'b0);
        check_bit({pfx, " done"}, done_a, 1'b0);
        check_bit({pfx, " error"}, error_a, 1'b0);
    endtask

    // Offer one byte from a falling edge until it is taken; returns on the
    // falling edge after the accepting rising edge.
    task automatic apply_stimulus(input logic [7:0] b);
        int guard;
        guard      = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready_sel !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            tests_run++;
            tests_failed++;
            $error("[TB] FAIL byte_ready wait: observed 0 expected 1");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic apply_gappy(input logic [7:0] b);
        int gap;
        gap = int'($urandom_range(0, 2));
        repeat (gap) @(negedge clk);
        apply_stimulus(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        apply_stimulus(w[7:0]);
        apply_stimulus(w[15:8]);
        apply_stimulus(w[23:16]);
        apply_stimulus(w[31:24]);
    endtask

    task automatic pulse_start(input bit which_b);
        if (which_b) start_b = 1'b1;
        else         start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic clear_logs();
        wa_addr.delete();
        wa_data.delete();
        wb_addr.delete();
        wb_data.delete();
        wb_cyc.delete();
    endtask

    // Directed sequence covering every scenario in order.
    initial begin
        reset      = 1'b1;
        start_a    = 1'b0;
        start_b    = 1'b0;
        sel        = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("in reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("idle");

        // A byte offered while idle must not be taken.
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (2) @(negedge clk);
        check_bit("idle refuses byte", bus_a.byte_ready, 1'b0);
        byte_valid = 1'b0;

        // Two-word load.
        clear_logs();
        pulse_start(1'b0);
        check_bit("t1 busy in hdr", busy_a, 1'b1);
        check_bit("t1 ready in hdr", bus_a.byte_ready, 1'b1);
        send_word(32'h0000_0002);
        send_word(32'h0010_0513);
        send_word(32'h0020_0593);
        check_bit("t1 last wr_en", bus_a.wr_en, 1'b1);
        check_output("t1 last wr_addr", bus_a.wr_addr, 32'h4);
        check_output("t1 last wr_data", bus_a.wr_data, 32'h0020_0593);
        check_bit("t1 ready low on last write", bus_a.byte_ready, 1'b0);
        check_bit("t1 done not yet", done_a, 1'b0);
        check_bit("t1 core held on last write", core_reset_a, 1'b1);
        @(negedge clk);
        check_bit("t1 done", done_a, 1'b1);
        check_bit("t1 core released", core_reset_a, 1'b0);
        check_bit("t1 wr_en off", bus_a.wr_en, 1'b0);
        check_bit("t1 busy off", busy_a, 1'b0);
        check_bit("t1 ready off", bus_a.byte_ready, 1'b0);
        check_output("t1 write count", 32'(wa_addr.size()), 32'd2);
        check_output("t1 addr0", wa_addr[0], 32'h0);
        check_output("t1 data0", wa_data[0], 32'h0010_0513);
        check_output("t1 addr1", wa_addr[1], 32'h4);
        check_output("t1 data1", wa_data[1], 32'h0020_0593);

        // Empty image.
        clear_logs();
        pulse_start(1'b0);
        check_bit("t2 core held after start", core_reset_a, 1'b1);
        check_bit("t2 done cleared", done_a, 1'b0);
        send_word(32'h0000_0000);
        check_bit("t2 done", done_a, 1'b1);
        check_bit("t2 core released", core_reset_a, 1'b0);
        check_output("t2 write count", 32'(wa_addr.size()), 32'd0);

        // Oversize header, then recovery.
        clear_logs();
        pulse_start(1'b0);
        send_word(32'h0000_0401);
        check_bit("t3 error", error_a, 1'b1);
        check_bit("t3 core held", core_reset_a, 1'b1);
        check_bit("t3 done low", done_a, 1'b0);
        check_bit("t3 busy low", busy_a, 1'b0);
        check_bit("t3 ready low", bus_a.byte_ready, 1'b0);
        repeat (3) @(negedge clk);
        check_output("t3 write count", 32'(wa_addr.size()), 32'd0);
        pulse_start(1'b0);
        check_bit("t3 error cleared", error_a, 1'b0);
        check_bit("t3 busy again", busy_a, 1'b1);
        send_word(32'h0000_0001);
        send_word(32'h1234_5678);
        check_bit("t3 wr_en", bus_a.wr_en, 1'b1);
        @(negedge clk);
        check_bit("t3 done", done_a, 1'b1);
        check_output("t3 write count after", 32'(wa_addr.size()), 32'd1);
        check_output("t3 addr", wa_addr[0], 32'h0);
        check_output("t3 data", wa_data[0], 32'h1234_5678);

        // Gaps in byte_valid and a start pulse mid-load.
        clear_logs();
        pulse_start(1'b0);
        apply_gappy(8'h01);
        apply_gappy(8'h00);
        pulse_start(1'b0);
        apply_gappy(8'h00);
        apply_gappy(8'h00);
        apply_gappy(8'hEF);
        apply_gappy(8'hBE);
        repeat (3) @(negedge clk);
        pulse_start(1'b0);
        check_bit("t4 busy through gaps", busy_a, 1'b1);
        check_output("t4 no early write", 32'(wa_addr.size()), 32'd0);
        apply_gappy(8'hAD);
        apply_gappy(8'hDE);
        @(negedge clk);
        check_bit("t4 done", done_a, 1'b1);
        check_output("t4 write count", 32'(wa_addr.size()), 32'd1);
        check_output("t4 addr", wa_addr[0], 32'h0);
        check_output("t4 data", wa_data[0], 32'hDEAD_BEEF);

        // Reset in the middle of word 1 of a three-word load.
        clear_logs();
        pulse_start(1'b0);
        send_word(32'h0000_0003);
        send_word(32'h4433_2211);
        apply_stimulus(8'h55);
        apply_stimulus(8'h66);
        check_output("t5 pre-reset wr_data", bus_a.wr_data, 32'h4433_2211);
        reset = 1'b0;
        #1;
        check_reset_values("t5 mid-load reset");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        clear_logs();
        pulse_start(1'b0);
        send_word(32'h0000_0003);
        check_bit("t5 core held in load", core_reset_a, 1'b1);
        send_word(32'hAAAA_0001);
        send_word(32'hBBBB_0002);
        send_word(32'hCCCC_0003);
        check_bit("t5 core held on last write", core_reset_a, 1'b1);
        @(negedge clk);
        check_bit("t5 core released", core_reset_a, 1'b0);
        check_output("t5 write count", 32'(wa_addr.size()), 32'd3);
        check_output("t5 addr0", wa_addr[0], 32'h0);
        check_output("t5 addr1", wa_addr[1], 32'h4);
        check_output("t5 addr2", wa_addr[2], 32'h8);
        check_output("t5 data0", wa_data[0], 32'hAAAA_0001);
        check_output("t5 data1", wa_data[1], 32'hBBBB_0002);
        check_output("t5 data2", wa_data[2], 32'hCCCC_0003);

        // Full capacity on the small instance, bytes back to back.
        sel = 1'b1;
        clear_logs();
        pulse_start(1'b1);
        send_word(32'h0000_0004);
        send_word(32'h0302_0100);
        send_word(32'h1312_1110);
        send_word(32'h2322_2120);
        send_word(32'h3332_3130);
        check_bit("t6 last wr_en", bus_b.wr_en, 1'b1);
        @(negedge clk);
        check_bit("t6 done", done_b, 1'b1);
        check_bit("t6 core released", core_reset_b, 1'b0);
        check_output("t6 write count", 32'(wb_addr.size()), 32'd4);
        check_output("t6 addr0", wb_addr[0], 32'h100);
        check_output("t6 addr1", wb_addr[1], 32'h104);
        check_output("t6 addr2", wb_addr[2], 32'h108);
        check_output("t6 addr3", wb_addr[3], 32'h10C);
        check_output("t6 data0", wb_data[0], 32'h0302_0100);
        check_output("t6 data3", wb_data[3], 32'h3332_3130);
        check_output("t6 spacing 0-1", 32'(wb_cyc[1] - wb_cyc[0]), 32'd4);
        check_output("t6 spacing 2-3", 32'(wb_cyc[3] - wb_cyc[2]), 32'd4);
        check_output("t6 other instance idle", 32'(wa_addr.size()), 32'd0);

        // One word past capacity on the small instance.
        pulse_start(1'b1);
        send_word(32'h0000_0005);
        check_bit("t6 N=5 error", error_b, 1'b1);
        check_bit("t6 N=5 core held", core_reset_b, 1'b1);
        sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
